// File: rtl/pdl_tuner_pkg.sv
// Shared types and default configuration for the PDL bias-trimming controller.
package pdl_tuner_pkg;

    localparam int unsigned DEL_W = 3;
    localparam logic [DEL_W-1:0] DEF_DEL_INIT = 3'b100;
    localparam int unsigned DEF_WIN_LOG2 = 6;
    localparam int unsigned DEF_THRESH   = 4;
    localparam int unsigned DEF_SETTLE   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_LOCKED
    } state_t;

    // Midpoint of a 2^win_log2 sample window: the ideal ones count.
    function automatic int unsigned half_of(input int unsigned win_log2);
        return 32'd1 << (win_log2 - 32'd1);
    endfunction

endpackage

// File: rtl/pdl_tuner_sync2.sv
// Two-flop synchronizer for a free-running asynchronous entropy source.
module pdl_tuner_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdl_tuner.sv
// Closed-loop PDL delay trimming: window ones-count drives del up/down until
// the raw stream is balanced, then forwards synchronized bits while locked.
module pdl_tuner
    import pdl_tuner_pkg::*;
#(
    parameter logic [DEL_W-1:0] DEL_INIT = DEF_DEL_INIT,
    parameter int unsigned      WIN_LOG2 = DEF_WIN_LOG2,
    parameter int unsigned      THRESH   = DEF_THRESH,
    parameter int unsigned      SETTLE   = DEF_SETTLE
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                stop,
    input  logic                z,
    output logic                en,
    output logic [DEL_W-1:0]    del,
    output logic                tuned,
    output logic                fail,
    output logic [WIN_LOG2:0]   ones_cnt,
    output logic                bit_out,
    output logic                bit_valid
);

    localparam int unsigned CNT_W   = WIN_LOG2 + 1;
    localparam int unsigned HALF    = half_of(WIN_LOG2);
    localparam int unsigned WIN_LEN = 32'd1 << WIN_LOG2;
    localparam logic [DEL_W-1:0] DEL_MAX = '1;

    state_t state, state_nxt;

    logic             z_s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic             en_nxt, tuned_nxt, fail_nxt, bit_valid_nxt;
    logic [DEL_W-1:0] del_nxt;
    logic [CNT_W-1:0] ones_nxt;

    logic settle_done, win_done, lock_eval;
    logic go_up, go_down, step, at_lim, sample_now;

    pdl_tuner_sync2 u_sync (
        .clk (clk),
        .rst (clr),
        .d   (z),
        .q   (z_s)
    );

    assign bit_out = z_s;

    assign settle_done = (tmr == CNT_W'(SETTLE - 1));
    assign win_done    = (tmr == CNT_W'(WIN_LEN - 1));
    // LOCKED reuses the slot after the last sample as its in-place evaluate.
    assign lock_eval   = (state == ST_LOCKED) && (tmr == CNT_W'(WIN_LEN));
    assign sample_now  = (state == ST_SAMPLE) || ((state == ST_LOCKED) && !lock_eval);

    // Tuning uses the tight band; a locked source is only retuned on a wider drift.
    always_comb begin
        go_up   = 1'b0;
        go_down = 1'b0;
        if (state == ST_EVAL) begin
            go_up   = 32'(cnt) > HALF + THRESH;
            go_down = 32'(cnt) < HALF - THRESH;
        end else if (lock_eval) begin
            go_up   = 32'(cnt) > HALF + 2 * THRESH;
            go_down = 32'(cnt) + 2 * THRESH < HALF;
        end
    end

    assign step   = go_up | go_down;
    assign at_lim = go_up ? (del == DEL_MAX) : (del == '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nxt = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_nxt = ST_SAMPLE;
                ST_SAMPLE: if (win_done) state_nxt = ST_EVAL;
                ST_EVAL: begin
                    if (step) state_nxt = at_lim ? ST_IDLE : ST_SETTLE;
                    else      state_nxt = ST_LOCKED;
                end
                ST_LOCKED: if (step) state_nxt = at_lim ? ST_IDLE : ST_SETTLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        del_nxt       = del;
        fail_nxt      = fail;
        ones_nxt      = ones_cnt;
        cnt_nxt       = cnt;
        tmr_nxt       = tmr + CNT_W'(1);
        en_nxt        = (state_nxt != ST_IDLE);
        tuned_nxt     = (state_nxt == ST_LOCKED);
        bit_valid_nxt = (state_nxt == ST_LOCKED);

        if (sample_now) cnt_nxt = cnt + CNT_W'(z_s);

        if (!stop) begin
            if ((state == ST_IDLE) && start) begin
                del_nxt  = DEL_INIT;
                fail_nxt = 1'b0;
            end
            if ((state == ST_EVAL) || lock_eval) begin
                ones_nxt = cnt;
                cnt_nxt  = '0;
            end
            if (step) begin
                if (at_lim)     fail_nxt = 1'b1;
                else if (go_up) del_nxt  = del + DEL_W'(1);
                else            del_nxt  = del - DEL_W'(1);
            end
        end

        if ((state_nxt != state) || lock_eval) tmr_nxt = '0;
        if (state_nxt == ST_IDLE) begin
            tmr_nxt = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            en        <= 1'b0;
            del       <= DEL_INIT;
            tuned     <= 1'b0;
            fail      <= 1'b0;
            ones_cnt  <= '0;
            bit_valid <= 1'b0;
            cnt       <= '0;
            tmr       <= '0;
        end else begin
            en        <= en_nxt;
            del       <= del_nxt;
            tuned     <= tuned_nxt;
            fail      <= fail_nxt;
            ones_cnt  <= ones_nxt;
            bit_valid <= bit_valid_nxt;
            cnt       <= cnt_nxt;
            tmr       <= tmr_nxt;
        end
    end

endmodule

// File: tb/tb_pdl_tuner.sv
// Bench for pdl_tuner: scripted and random z sources against a window-sum model.
module tb_pdl_tuner;

    localparam int HALF = 32;
    localparam int THR  = 4;
    localparam int WIN  = 64;
    localparam int ITER = 69;
    localparam int ZMAX = 32768;

    logic       clk;
    logic       clr;
    logic       start;
    logic       stop;
    logic       z;
    logic       en;
    logic [2:0] del;
    logic       tuned;
    logic       fail;
    logic [6:0] ones_cnt;
    logic       bit_out;
    logic       bit_valid;

    pdl_tuner dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .stop      (stop),
        .z         (z),
        .en        (en),
        .del       (del),
        .tuned     (tuned),
        .fail      (fail),
        .ones_cnt  (ones_cnt),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;
    int pct    = 50;
    bit zd [0:ZMAX-1];
    int m_del  = 4;
    bit m_fail = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive the next z value, record it, advance one edge, settle past it.
    task automatic tick();
        int k;
        bit v;
        k = cyc + 1;
        if (k >= ZMAX) begin
            $display("FAIL tick_budget got=%0d exp=%0d", k, ZMAX - 1);
            $fatal(1);
        end
        case (mode)
            0:       v = 1'b0;
            1:       v = 1'b1;
            2:       v = k[0];
            3:       v = (k % 4) != 3;
            default: v = ($urandom_range(0, 99) < pct);
        endcase
        z     = v;
        zd[k] = v;
        @(posedge clk);
        cyc = k;
        #1;
    endtask

    function automatic int win_sum(input int first);
        int s;
        s = 0;
        for (int i = 0; i < WIN; i++) s += int'(zd[first + i]);
        return s;
    endfunction

    function automatic int step_of(input int c, input int tol);
        if (c > HALF + tol) return 1;
        if (c < HALF - tol) return -1;
        return 0;
    endfunction

    // Apply a delay step to the model; returns 1 when the range is exhausted.
    function automatic bit apply_step(input int dir);
        if ((dir > 0 && m_del == 7) || (dir < 0 && m_del == 0)) begin
            m_fail = 1'b1;
            return 1'b1;
        end
        m_del = m_del + dir;
        return 1'b0;
    endfunction

    task automatic do_start(output int b);
        start = 1'b1;
        tick();
        start  = 1'b0;
        b      = cyc;
        m_del  = 4;
        m_fail = 1'b0;
        check("start_en", 32'(en), 1);
        check("start_del", 32'(del), 32'(m_del));
        check("start_fail", 32'(fail), 0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_en", 32'(en), 0);
        check("stop_tuned", 32'(tuned), 0);
        check("stop_valid", 32'(bit_valid), 0);
        check("stop_del", 32'(del), 32'(m_del));
        check("stop_fail", 32'(fail), 32'(m_fail));
    endtask

    // res: 0 locked (e = lock edge), 1 failed, 2 still tuning after max_it
    task automatic tune(input int b_in, input int max_it, output int res, output int e);
        int b;
        b   = b_in;
        res = 2;
        e   = cyc;
        for (int it = 0; it < max_it; it++) begin
            int c;
            int dir;
            for (int i = 0; i < ITER; i++) begin
                tick();
                if (i == 34) begin
                    check("iter_en", 32'(en), 1);
                    check("iter_valid", 32'(bit_valid), 0);
                end
            end
            c = win_sum(b + 3);
            check("eval_ones", 32'(ones_cnt), 32'(c));
            dir = step_of(c, THR);
            if (dir == 0) begin
                check("eval_tuned", 32'(tuned), 1);
                check("eval_valid", 32'(bit_valid), 1);
                check("eval_del", 32'(del), 32'(m_del));
                res = 0;
                e   = cyc;
                return;
            end
            if (apply_step(dir)) begin
                check("evalf_fail", 32'(fail), 1);
                check("evalf_en", 32'(en), 0);
                check("evalf_tuned", 32'(tuned), 0);
                check("evalf_del", 32'(del), 32'(m_del));
                res = 1;
                return;
            end
            check("evals_del", 32'(del), 32'(m_del));
            check("evals_en", 32'(en), 1);
            check("evals_tuned", 32'(tuned), 0);
            b = cyc;
        end
    endtask

    // res: 0 still locked, 1 failed, 2 drifted back into settling (e_out = new start edge)
    task automatic locked_win(input int e_in, output int res, output int e_out);
        int c;
        int dir;
        bit f;
        for (int i = 1; i <= WIN; i++) begin
            tick();
            check("lk_valid", 32'(bit_valid), 1);
            check("lk_bit", 32'(bit_out), 32'(zd[cyc - 1]));
        end
        tick();
        e_out = cyc;
        c = win_sum(e_in - 1);
        check("lk_ones", 32'(ones_cnt), 32'(c));
        dir = step_of(c, 2 * THR);
        if (dir == 0) begin
            check("lk_eval_valid", 32'(bit_valid), 1);
            check("lk_eval_tuned", 32'(tuned), 1);
            check("lk_eval_del", 32'(del), 32'(m_del));
            res = 0;
            return;
        end
        f = apply_step(dir);
        check("drift_tuned", 32'(tuned), 0);
        check("drift_valid", 32'(bit_valid), 0);
        check("drift_del", 32'(del), 32'(m_del));
        check("drift_fail", 32'(fail), 32'(m_fail));
        check("drift_en", 32'(en), f ? 0 : 1);
        res = f ? 1 : 2;
    endtask

    initial begin
        int b;
        int e;
        int res;
        clr   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        z     = 1'b0;
        tick();
        tick();
        check("rst_en", 32'(en), 0);
        check("rst_del", 32'(del), 4);
        check("rst_ones", 32'(ones_cnt), 0);
        check("rst_valid", 32'(bit_valid), 0);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("idle_en", 32'(en), 0);
        check("idle_tuned", 32'(tuned), 0);

        // balanced source locks at the initial delay, then drifts to 75% ones
        mode = 2;
        do_start(b);
        tune(b, 1, res, e);
        check("bal_ones", 32'(ones_cnt), 32);
        check("bal_tuned", 32'(tuned), 1);
        locked_win(e, res, e);
        mode = 3;
        locked_win(e, res, e);
        check("drift_del_101", 32'(del), 5);
        do_stop();

        // stop while locked, then start+stop together stays idle
        mode = 2;
        do_start(b);
        tune(b, 1, res, e);
        locked_win(e, res, e);
        for (int i = 0; i < 10; i++) tick();
        do_stop();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("ss_en", 32'(en), 0);
        check("ss_tuned", 32'(tuned), 0);

        // stuck-high runs off the top of the delay range
        mode = 1;
        do_start(b);
        tune(b, 8, res, e);
        check("hi_del", 32'(del), 7);
        check("hi_fail", 32'(fail), 1);
        check("hi_ones", 32'(ones_cnt), 64);
        for (int i = 0; i < 20; i++) tick();
        check("hi_fail_hold", 32'(fail), 1);
        check("hi_en_hold", 32'(en), 0);

        // asynchronous clear in the middle of a sample window
        do_start(b);
        tune(b, 1, res, e);
        for (int i = 0; i < 30; i++) tick();
        #2;
        clr = 1'b1;
        #1;
        m_del  = 4;
        m_fail = 1'b0;
        check("clr_en", 32'(en), 0);
        check("clr_del", 32'(del), 4);
        check("clr_tuned", 32'(tuned), 0);
        check("clr_fail", 32'(fail), 0);
        check("clr_ones", 32'(ones_cnt), 0);
        tick();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("clr_idle_en", 32'(en), 0);

        // stuck-low runs off the bottom of the delay range
        mode = 0;
        do_start(b);
        tune(b, 8, res, e);
        check("lo_del", 32'(del), 0);
        check("lo_fail", 32'(fail), 1);
        check("lo_ones", 32'(ones_cnt), 0);

        // random-density sources
        for (int t = 0; t < 10; t++) begin
            int nwin;
            mode = 4;
            pct  = int'($urandom_range(30, 70));
            do_start(b);
            tune(b, 6, res, e);
            nwin = 0;
            while (res == 0 && nwin < 4) begin
                locked_win(e, res, e);
                nwin++;
                if (res == 2) tune(e, 3, res, e);
            end
            do_stop();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
